// File: rtl/binary_tower_pkg.sv
// Shared types and constants for the 32-bit binary tower field blocks.
package binary_tower_pkg;

   typedef logic [31:0] gf32_t;

   localparam gf32_t ALPHA_32 = 32'h00010000;

   typedef enum logic [1:0] {
      IDLE,
      BUSY,
      DONE
   } state_t;

endpackage

// File: rtl/binary_tower_32b_mul_alpha.sv
// Combinational multiply-by-alpha in the 32-bit binary tower field.
module binary_tower_32b_mul_alpha
   import binary_tower_pkg::*;
(
   input  logic        ap_clk,
   input  logic        ap_rst,
   input  logic        ap_ce,
   input  logic [31:0] a,
   output logic [31:0] ap_return
);

   // Each level maps {a1, a0} to {a0 ^ alpha_lower(a1), a1}
   function automatic logic [1:0] ma2(input logic [1:0] x);
      return {x[1] ^ x[0], x[1]};
   endfunction

   function automatic logic [3:0] ma4(input logic [3:0] x);
      return {x[1:0] ^ ma2(x[3:2]), x[3:2]};
   endfunction

   function automatic logic [7:0] ma8(input logic [7:0] x);
      return {x[3:0] ^ ma4(x[7:4]), x[7:4]};
   endfunction

   function automatic logic [15:0] ma16(input logic [15:0] x);
      return {x[7:0] ^ ma8(x[15:8]), x[15:8]};
   endfunction

   function automatic gf32_t ma32(input gf32_t x);
      return {x[15:0] ^ ma16(x[31:16]), x[31:16]};
   endfunction

   // Clock and reset exist only for interface compatibility with the pipelined variant
   logic unused_ok;
   assign unused_ok = ap_clk ^ ap_rst;

   assign ap_return = ap_ce ? ma32(a) : a;

endmodule

// File: rtl/binary_tower_32b_mul_alpha_pow.sv
// Iterative a * alpha^n: one multiply-by-alpha step per cycle with valid/ready handshakes.
module binary_tower_32b_mul_alpha_pow
   import binary_tower_pkg::*;
#(
   parameter int N_W = 5
) (
   input  logic           ap_clk,
   input  logic           ap_rst,
   input  logic           in_valid,
   output logic           in_ready,
   input  logic [31:0]    in_a,
   input  logic [N_W-1:0] in_n,
   output logic           out_valid,
   input  logic           out_ready,
   output logic [31:0]    out_data,
   output logic           busy
);

   localparam logic [N_W-1:0] CNT_ONE = N_W'(1);

   state_t         state;
   gf32_t          acc;
   gf32_t          acc_next;
   logic [N_W-1:0] cnt;
   logic           accept;

   binary_tower_32b_mul_alpha u_mul_alpha (
      .ap_clk    (ap_clk),
      .ap_rst    (ap_rst),
      .ap_ce     (1'b1),
      .a         (acc),
      .ap_return (acc_next)
   );

   // A finished result frees the slot in the same cycle it is taken, so DONE can accept back-to-back
   assign in_ready  = !ap_rst && ((state == IDLE) || ((state == DONE) && out_ready));
   assign out_valid = (state == DONE);
   assign busy      = (state == BUSY);
   assign out_data  = (state == DONE) ? acc : '0;
   assign accept    = in_valid && in_ready;

   always_ff @(posedge ap_clk) begin
      if (ap_rst) begin
         state <= IDLE;
         acc   <= '0;
         cnt   <= '0;
      end else if (accept) begin
         acc   <= in_a;
         cnt   <= in_n;
         state <= (in_n != '0) ? BUSY : DONE;
      end else begin
         case (state)
            BUSY: begin
               acc <= acc_next;
               cnt <= cnt - CNT_ONE;
               if (cnt == CNT_ONE) begin
                  state <= DONE;
               end
            end
            DONE: begin
               if (out_ready) begin
                  state <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_binary_tower_32b_mul_alpha_pow.sv
// Directed and randomized checks of the alpha-power block against an independent bit-level model.
module tb_binary_tower_32b_mul_alpha_pow;

   logic        ap_clk;
   logic        ap_rst;
   logic        in_valid;
   logic        in_ready;
   logic [31:0] in_a;
   logic [4:0]  in_n;
   logic        out_valid;
   logic        out_ready;
   logic [31:0] out_data;
   logic        busy;

   int checkCount;
   int errorCount;

   binary_tower_32b_mul_alpha_pow #(.N_W(5)) dut (
      .ap_clk    (ap_clk),
      .ap_rst    (ap_rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_a      (in_a),
      .in_n      (in_n),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_data  (out_data),
      .busy      (busy)
   );

   initial ap_clk = 1'b0;
   always #5 ap_clk = ~ap_clk;

   task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      checkCount++;
      if (observed !== expected) begin
         errorCount++;
         $display("[TB] FAIL %s: got %h expected %h", tag, observed, expected);
      end
   endtask

   // Bottom-up evaluation: build alpha times the top w-bit segment for w = 1, 2, 4, ... 32
   function automatic logic [31:0] refMulAlpha(input logic [31:0] x);
      logic [31:0] t, s, hi, lo, m;
      int h;
      t = {31'b0, x[31]};
      for (int w = 2; w <= 32; w = w * 2) begin
         h  = w / 2;
         m  = (32'h1 << h) - 32'h1;
         s  = x >> (32 - w);
         hi = (s >> h) & m;
         lo = s & m;
         t  = ((lo ^ t) << h) | hi;
      end
      return t;
   endfunction

   function automatic logic [31:0] refPow(input logic [31:0] a, input int n);
      logic [31:0] r;
      r = a;
      for (int i = 0; i < n; i++) r = refMulAlpha(r);
      return r;
   endfunction

   // One request from accept to pop; stall holds out_ready low for that many cycles of DONE
   task automatic applyStimulus(input logic [31:0] a, input logic [4:0] n, input logic [31:0] expected,
                                input int stall, input string tag);
      int lat;
      logic [31:0] junk;
      in_a      = a;
      in_n      = n;
      in_valid  = 1'b1;
      out_ready = (stall == 0);
      #1;
      checkOutput({tag, "_in_ready"}, {31'b0, in_ready}, 32'd1);
      @(negedge ap_clk);
      junk     = $urandom;
      in_valid = 1'b0;
      in_a     = junk;
      in_n     = junk[4:0];
      lat = 1;
      while (!out_valid && lat < 100) begin
         @(negedge ap_clk);
         lat++;
      end
      checkOutput({tag, "_latency"}, lat, 32'(int'(n) + 1));
      checkOutput({tag, "_data"}, out_data, expected);
      for (int i = 0; i < stall; i++) begin
         @(negedge ap_clk);
         checkOutput({tag, "_hold_data"}, out_data, expected);
      end
      out_ready = 1'b1;
      @(negedge ap_clk);
      checkOutput({tag, "_popped"}, {31'b0, out_valid}, 32'd0);
   endtask

   initial begin
      logic [31:0] expected;
      logic [31:0] r;
      int lat;
      int seen;

      checkCount = 0;
      errorCount = 0;
      ap_rst    = 1'b1;
      in_valid  = 1'b0;
      in_a      = '0;
      in_n      = '0;
      out_ready = 1'b0;

      repeat (2) @(negedge ap_clk);
      checkOutput("rst_in_ready", {31'b0, in_ready}, 32'd0);
      checkOutput("rst_out_valid", {31'b0, out_valid}, 32'd0);
      checkOutput("rst_busy", {31'b0, busy}, 32'd0);
      checkOutput("rst_out_data", out_data, 32'd0);
      ap_rst = 1'b0;
      #1;
      checkOutput("post_rst_in_ready", {31'b0, in_ready}, 32'd1);

      applyStimulus(32'h00000001, 5'd1, 32'h00010000, 0, "one_n1");
      applyStimulus(32'h00000001, 5'd2, 32'h01000001, 0, "one_n2");
      applyStimulus(32'h00000001, 5'd3, 32'h10000100, 0, "one_n3");
      applyStimulus(32'hDEADBEEF, 5'd0, 32'hDEADBEEF, 0, "n0");
      applyStimulus(32'h00000000, 5'd31, 32'h00000000, 1, "zero_n31");

      // Max exponent under backpressure, then back-to-back accept from DONE
      expected = refPow(32'h00000001, 31);
      in_a = 32'h00000001; in_n = 5'd31; in_valid = 1'b1; out_ready = 1'b0;
      @(negedge ap_clk);
      in_valid = 1'b0;
      lat = 1;
      while (!out_valid && lat < 100) begin
         @(negedge ap_clk);
         lat++;
      end
      checkOutput("max_latency", lat, 32'd32);
      for (int i = 0; i < 10; i++) begin
         r = $urandom;
         in_valid = 1'b1; in_a = r; in_n = r[4:0];
         #1;
         checkOutput("stall_data", out_data, expected);
         checkOutput("stall_in_ready", {31'b0, in_ready}, 32'd0);
         checkOutput("stall_out_valid", {31'b0, out_valid}, 32'd1);
         @(negedge ap_clk);
      end
      in_a = 32'h00000001; in_n = 5'd1; in_valid = 1'b1; out_ready = 1'b1;
      #1;
      checkOutput("b2b_in_ready", {31'b0, in_ready}, 32'd1);
      @(negedge ap_clk);
      in_valid = 1'b0;
      checkOutput("b2b_busy", {31'b0, busy}, 32'd1);
      checkOutput("b2b_not_valid", {31'b0, out_valid}, 32'd0);
      @(negedge ap_clk);
      checkOutput("b2b_valid", {31'b0, out_valid}, 32'd1);
      checkOutput("b2b_data", out_data, 32'h00010000);
      @(negedge ap_clk);

      // Reset in the middle of a long operation
      in_a = 32'h12345678; in_n = 5'd20; in_valid = 1'b1; out_ready = 1'b1;
      @(negedge ap_clk);
      in_valid = 1'b0;
      repeat (4) @(negedge ap_clk);
      ap_rst = 1'b1;
      @(negedge ap_clk);
      checkOutput("abort_busy", {31'b0, busy}, 32'd0);
      checkOutput("abort_out_valid", {31'b0, out_valid}, 32'd0);
      checkOutput("abort_out_data", out_data, 32'd0);
      checkOutput("abort_in_ready", {31'b0, in_ready}, 32'd0);
      ap_rst = 1'b0;
      #1;
      checkOutput("abort_release_ready", {31'b0, in_ready}, 32'd1);
      seen = 0;
      repeat (30) begin
         @(negedge ap_clk);
         if (out_valid) seen++;
      end
      checkOutput("abort_no_result", seen, 32'd0);

      for (int k = 0; k < 16; k++) begin
         logic [31:0] a;
         logic [31:0] t;
         a = $urandom;
         t = $urandom;
         applyStimulus(a, t[4:0], refPow(a, int'(t[4:0])), int'($urandom_range(0, 3)), "rand");
      end

      $display("CHECKS %0d ERRORS %0d", checkCount, errorCount);
      $finish;
   end

endmodule

// File: doc/binary_tower_32b_mul_alpha_pow.md
BINARY_TOWER_32B_MUL_ALPHA_POW -- requirements
Module: binary_tower_32b_mul_alpha_pow

Interface
REQ-001 Parameter N_W, default 5, width of the exponent input; max exponent 2^N_W-1.
REQ-002 ap_clk  input  1  sole clock; all state updates on rising edge.
REQ-003 ap_rst  input  1  reset; synchronous, active-high.
REQ-004 in_valid  input  1  request valid.
REQ-005 in_ready  output  1  block can accept a request this cycle.
REQ-006 in_a  input  32  GF(2^32) tower element operand.
REQ-007 in_n  input  N_W  exponent n; result is in_a * alpha^n.
REQ-008 out_valid  output  1  result valid.
REQ-009 out_ready  input  1  downstream accepts result.
REQ-010 out_data  output  32  result element.
REQ-011 busy  output  1  high while iterating (state BUSY).

Function
REQ-012 Block SHALL compute in_a * alpha^n in the 32b binary tower, alpha = top-level generator (alpha*1 = 32'h00010000).
REQ-013 One mul_alpha step SHALL map {a1[15:0],a0[15:0]} to {a0 ^ mul_alpha16(a1), a1}, recursively down to 2b level {a1^a0, a1}.
REQ-014 FSM states: IDLE, BUSY, DONE.
REQ-015 IDLE: in_ready=1; on in_valid, latch acc<=in_a, cnt<=in_n; go BUSY if in_n!=0, else DONE.
REQ-016 BUSY: in_ready=0; each cycle acc<=mul_alpha(acc), cnt<=cnt-1; when cnt==1 this cycle, go DONE.
REQ-017 DONE: out_valid=1, out_data=acc; acc and out_data SHALL stay stable until out_ready.
REQ-018 Latency from accept to out_valid SHALL be n+1 cycles; throughput one request per n+1 cycles without backpressure.
REQ-019 DONE with out_ready=1: in_ready=1 same cycle; if in_valid also 1, accept new request as in IDLE (back-to-back, no bubble); else go IDLE.
REQ-020 DONE with out_ready=0: in_ready=0; in_valid ignored.
REQ-021 n=0 SHALL return in_a unchanged after 1 cycle.
REQ-022 n=2^N_W-1 SHALL complete without counter wrap; cnt never decremented below 0.
REQ-023 in_ready, out_valid, busy SHALL be registered-state decodes only (no combinational path from in_valid to in_ready); in_ready in DONE depends combinationally on out_ready only.
REQ-024 in_a/in_n values when in_valid=0 or in_ready=0 SHALL NOT affect state.

Reset
REQ-025 While ap_rst=1: state=IDLE, acc=0, cnt=0, out_valid=0, out_data=0, busy=0, in_ready=0.
REQ-026 First cycle after ap_rst deasserts, in_ready=1.
REQ-027 Reset asserted in BUSY or DONE SHALL abort the operation; pending result discarded, never presented.

Structure
REQ-028 Shared package binary_tower_pkg SHALL hold: 32b element typedef, constant ALPHA_32 = 32'h00010000, FSM state enum.
REQ-029 The one mul_alpha step SHALL be one instance of the existing combinational sub-module binary_tower_32b_mul_alpha (ports ap_clk, ap_ce, a, ap_return, ap_rst), ap_ce tied 1; no other sub-modules.
REQ-030 Single always block for FSM/datapath registers; no latches.

Verification
REQ-031 in_a=32'h00000001, n=1, out_ready=1 -> out_valid 2 cycles after accept, out_data=32'h00010000.
REQ-032 in_a=32'h00000001, n=2 -> out_data=32'h01000001 after 3 cycles.
REQ-033 in_a=32'hDEADBEEF, n=0 -> out_data=32'hDEADBEEF 1 cycle after accept.
REQ-034 n=31, out_ready=0 for 10 cycles after out_valid -> out_data stable, in_ready=0 throughout; then out_ready=1 with in_valid=1 (in_a=1,n=1) -> new request accepted same cycle, next result 32'h00010000 two cycles later.
REQ-035 ap_rst pulsed mid-BUSY (n=20, cycle 5) -> next cycle all outputs 0, no out_valid for aborted request, in_ready=1 after release.
REQ-036 Random a,n streams with random out_ready vs. reference model (n-fold mul_alpha) -> all results match, order preserved, no drops or duplicates.
